// File: rtl/gt_bus_pkg.sv
// Shared bus definitions for the cartridge ROM port: requester tags and
// default widths used by the arbiter and the top-level address decode.
package gt_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [15:0] ROM_BASE = 16'h8000;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_DMA  = 2'd2
    } req_tag_e;

endpackage

// File: rtl/gt_rd_tag_pipe.sv
// Fixed-depth shift register of requester tags; the tag leaving the last
// stage names the port that owns the mapper read data in that cycle.
module gt_rd_tag_pipe
    import gt_bus_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     sys_clk,
    input  logic     reset,
    input  req_tag_e i_tag,
    output req_tag_e o_tag
);

    req_tag_e r_stage [DEPTH];

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= REQ_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/gt_rom_bus_arbiter.sv
// CPU/DMA arbiter for the ROM mapper port: fixed CPU priority with a
// starvation guard, registered issue stage and tagged read-data return.
module gt_rom_bus_arbiter
    import gt_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ROM_LATENCY = 1,
    parameter int CPU_MAX_RUN = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rnw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rnw,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              rom_ce,
    output logic              rom_rnw,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              dma_boost
);

    logic [3:0]        r_run_cnt;
    logic              r_dma_boost;
    logic              r_rom_ce;
    logic              r_rom_rnw;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_rom_wdata;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_dma_hold;
    req_tag_e          r_issue_tag;

    logic              w_run_max;
    logic              w_cpu_gnt;
    logic              w_dma_gnt;
    logic              w_sel_rnw;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [3:0]        w_run_next;
    req_tag_e          w_new_tag;
    req_tag_e          w_ret_tag;

    assign w_run_max = (r_run_cnt == 4'(CPU_MAX_RUN));

    always_comb begin
        w_cpu_gnt   = !reset && cpu_req && (!dma_req || !w_run_max);
        w_dma_gnt   = !reset && dma_req && !w_cpu_gnt;
        w_sel_rnw   = w_dma_gnt ? dma_rnw   : cpu_rnw;
        w_sel_addr  = w_dma_gnt ? dma_addr  : cpu_addr;
        w_sel_wdata = w_dma_gnt ? dma_wdata : cpu_wdata;

        w_new_tag = REQ_NONE;
        if (w_cpu_gnt && cpu_rnw) begin
            w_new_tag = REQ_CPU;
        end else if (w_dma_gnt && dma_rnw) begin
            w_new_tag = REQ_DMA;
        end

        // Run length only counts CPU wins while DMA is actually waiting.
        w_run_next = r_run_cnt;
        if (!dma_req || w_dma_gnt) begin
            w_run_next = 4'd0;
        end else if (w_cpu_gnt && !w_run_max) begin
            w_run_next = r_run_cnt + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_run_cnt   <= 4'd0;
            r_dma_boost <= 1'b0;
            r_rom_ce    <= 1'b0;
            r_rom_rnw   <= 1'b1;
            r_rom_addr  <= '0;
            r_rom_wdata <= '0;
            r_cpu_hold  <= '0;
            r_dma_hold  <= '0;
            r_issue_tag <= REQ_NONE;
        end else begin
            r_run_cnt   <= w_run_next;
            r_dma_boost <= (w_run_next == 4'(CPU_MAX_RUN));
            r_issue_tag <= w_new_tag;
            r_rom_ce    <= w_cpu_gnt || w_dma_gnt;
            if (w_cpu_gnt || w_dma_gnt) begin
                r_rom_rnw   <= w_sel_rnw;
                r_rom_addr  <= w_sel_addr;
                r_rom_wdata <= w_sel_wdata;
            end else begin
                r_rom_rnw   <= 1'b1;
            end
            if (w_ret_tag == REQ_CPU) begin
                r_cpu_hold <= rom_rdata;
            end
            if (w_ret_tag == REQ_DMA) begin
                r_dma_hold <= rom_rdata;
            end
        end
    end

    // Tag enters after the issue register, so it exits with the mapper data.
    gt_rd_tag_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_tag_pipe (
        .sys_clk (sys_clk),
        .reset   (reset),
        .i_tag   (r_issue_tag),
        .o_tag   (w_ret_tag)
    );

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_rvalid = (w_ret_tag == REQ_CPU);
    assign dma_rvalid = (w_ret_tag == REQ_DMA);
    assign cpu_rdata  = cpu_rvalid ? rom_rdata : r_cpu_hold;
    assign dma_rdata  = dma_rvalid ? rom_rdata : r_dma_hold;
    assign rom_ce     = r_rom_ce;
    assign rom_rnw    = r_rom_rnw;
    assign rom_addr   = r_rom_addr;
    assign rom_wdata  = r_rom_wdata;
    assign dma_boost  = r_dma_boost;

endmodule

// File: tb/tb_gt_rom_bus_arbiter.sv
// Bench for gt_rom_bus_arbiter: default build checked by vector table, hand
// sequences and random traffic against a model; a second build (latency 3,
// run limit 1) checks alternation and streaming read latency.
module tb_gt_rom_bus_arbiter;

    localparam int P_LAT = 1;
    localparam int P_MAX = 4;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic        cpu_req = 0, cpu_rnw = 1, dma_req = 0, dma_rnw = 1;
    logic [15:0] cpu_addr = 0, dma_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_wdata = 0, rom_rdata = 0;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rom_ce, rom_rnw, dma_boost;
    logic [7:0]  cpu_rdata, dma_rdata, rom_wdata;
    logic [15:0] rom_addr;

    logic        b_cpu_req = 0, b_cpu_rnw = 1, b_dma_req = 0, b_dma_rnw = 1;
    logic [15:0] b_cpu_addr = 0, b_dma_addr = 0;
    logic [7:0]  b_cpu_wdata = 0, b_dma_wdata = 0, b_rom_rdata = 0;
    logic        b_cpu_gnt, b_cpu_rvalid, b_dma_gnt, b_dma_rvalid, b_rom_ce, b_rom_rnw, b_dma_boost;
    logic [7:0]  b_cpu_rdata, b_dma_rdata, b_rom_wdata;
    logic [15:0] b_rom_addr;

    gt_rom_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LATENCY(P_LAT), .CPU_MAX_RUN(P_MAX)) u_dut (
        .sys_clk(sys_clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .rom_ce(rom_ce), .rom_rnw(rom_rnw), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .rom_rdata(rom_rdata), .dma_boost(dma_boost)
    );

    gt_rom_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LATENCY(3), .CPU_MAX_RUN(1)) u_dut_b (
        .sys_clk(sys_clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_addr(b_cpu_addr), .cpu_rnw(b_cpu_rnw), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
        .dma_req(b_dma_req), .dma_addr(b_dma_addr), .dma_rnw(b_dma_rnw), .dma_wdata(b_dma_wdata),
        .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata), .dma_rvalid(b_dma_rvalid),
        .rom_ce(b_rom_ce), .rom_rnw(b_rom_rnw), .rom_addr(b_rom_addr), .rom_wdata(b_rom_wdata),
        .rom_rdata(b_rom_rdata), .dma_boost(b_dma_boost)
    );

    typedef struct {
        logic cr; logic [15:0] ca; logic crnw; logic [7:0] cwd;
        logic dr; logic [15:0] da; logic drnw; logic [7:0] dwd;
        logic ecg; logic edg; logic eb;
    } vec_t;

    typedef struct {
        int         due;
        logic       is_dma;
        logic [7:0] data;
    } ret_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state for the default build
    int          m_run = 0;
    logic        x_ce = 0, x_rnw = 1;
    logic [15:0] x_addr = 0;
    logic [7:0]  x_wd = 0, x_cpu_d = 0, x_dma_d = 0;
    ret_t        retq[$];

    logic [7:0]  m1_last = 0, m3_last = 0;
    logic [7:0]  hist3 [3];

    vec_t tbl[$];

    function automatic logic [7:0] f_rom(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h29;
    endfunction

    function automatic vec_t mk(input logic cr, input logic [15:0] ca, input logic crnw,
                                input logic [7:0] cwd, input logic dr, input logic [15:0] da,
                                input logic drnw, input logic [7:0] dwd,
                                input logic ecg, input logic edg, input logic eb);
        vec_t v;
        v.cr = cr; v.ca = ca; v.crnw = crnw; v.cwd = cwd;
        v.dr = dr; v.da = da; v.drnw = drnw; v.dwd = dwd;
        v.ecg = ecg; v.edg = edg; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mapper models: registered data, LAT cycles after the access is presented.
    task automatic tick();
        m1_last = (rom_ce && rom_rnw) ? f_rom(rom_addr) : 8'hEE;
        m3_last = (b_rom_ce && b_rom_rnw) ? f_rom(b_rom_addr) : 8'hEE;
        @(posedge sys_clk);
        #1;
        rom_rdata   = m1_last;
        hist3[2]    = hist3[1];
        hist3[1]    = hist3[0];
        hist3[0]    = m3_last;
        b_rom_rdata = hist3[2];
        cyc++;
    endtask

    task automatic do_cycle(input logic rst_i, input vec_t v,
                            output logic o_cg, output logic o_dg, output logic o_b,
                            output logic e_cg, output logic e_dg);
        logic e_cv, e_dv;
        ret_t r;
        reset = rst_i;
        cpu_req = v.cr; cpu_addr = v.ca; cpu_rnw = v.crnw; cpu_wdata = v.cwd;
        dma_req = v.dr; dma_addr = v.da; dma_rnw = v.drnw; dma_wdata = v.dwd;
        #2;
        e_cg = !rst_i && v.cr && (!v.dr || m_run != P_MAX);
        e_dg = !rst_i && v.dr && !e_cg;
        if (rst_i) begin
            m_run = 0; x_ce = 0; x_rnw = 1; x_addr = 0; x_wd = 0;
            x_cpu_d = 0; x_dma_d = 0;
            retq.delete();
        end
        e_cv = 0; e_dv = 0;
        if (retq.size() != 0 && retq[0].due == cyc) begin
            if (retq[0].is_dma) begin e_dv = 1; x_dma_d = retq[0].data; end
            else                begin e_cv = 1; x_cpu_d = retq[0].data; end
            void'(retq.pop_front());
        end
        chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
        chk("dma_gnt",    32'(dma_gnt),    32'(e_dg));
        chk("dma_boost",  32'(dma_boost),  32'(m_run == P_MAX));
        chk("rom_ce",     32'(rom_ce),     32'(x_ce));
        chk("rom_rnw",    32'(rom_rnw),    32'(x_rnw));
        chk("rom_addr",   32'(rom_addr),   32'(x_addr));
        chk("rom_wdata",  32'(rom_wdata),  32'(x_wd));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e_dv));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(x_cpu_d));
        chk("dma_rdata",  32'(dma_rdata),  32'(x_dma_d));
        o_cg = cpu_gnt; o_dg = dma_gnt; o_b = dma_boost;
        if (!rst_i) begin
            if (e_cg || e_dg) begin
                x_ce   = 1;
                x_rnw  = e_dg ? v.drnw : v.crnw;
                x_addr = e_dg ? v.da   : v.ca;
                x_wd   = e_dg ? v.dwd  : v.cwd;
                if (x_rnw) begin
                    r.due = cyc + 1 + P_LAT; r.is_dma = e_dg; r.data = f_rom(x_addr);
                    retq.push_back(r);
                end
            end else begin
                x_ce  = 0;
                x_rnw = 1;
            end
            if (!v.dr || e_dg)               m_run = 0;
            else if (e_cg && m_run < P_MAX)  m_run++;
        end
    endtask

    initial begin
        vec_t idle, both, pend;
        logic ocg, odg, ob, ecg, edg, pc, pd;
        logic [15:0] pca, pda;
        logic pcrnw, pdrnw;
        logic [7:0] pcwd, pdwd;
        hist3[0] = 0; hist3[1] = 0; hist3[2] = 0;
        idle = mk(0, 16'h0000, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 0, 0, 0);
        both = mk(1, 16'h8010, 1, 8'h00, 1, 16'h9000, 1, 8'h00, 1, 0, 0);

        tbl.push_back(mk(1, 16'h8000, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 1, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        for (int i = 0; i < 4; i++) tbl.push_back(both);
        tbl.push_back(mk(1, 16'h8010, 1, 8'h00, 1, 16'h9000, 1, 8'h00, 0, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(both);
        tbl.push_back(mk(1, 16'h8010, 1, 8'h00, 1, 16'h9000, 1, 8'h00, 0, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(both);
        tbl.push_back(mk(1, 16'h8010, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 1, 0, 1));
        tbl.push_back(both);
        tbl.push_back(mk(1, 16'h8000, 0, 8'h55, 0, 16'h0000, 1, 8'h00, 1, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(1, 16'hFFFC, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 8'h00, 1, 16'h9000, 1, 8'h00, 0, 1, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(1, 16'h8123, 0, 8'h77, 0, 16'h0000, 1, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 16'h8123, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 1, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);

        @(posedge sys_clk);
        #1;
        do_cycle(1, both, ocg, odg, ob, ecg, edg);
        chk("rst_gated_cpu_gnt", 32'(ocg), 32'd0);
        tick();
        do_cycle(1, idle, ocg, odg, ob, ecg, edg);
        tick();

        foreach (tbl[i]) begin
            do_cycle(0, tbl[i], ocg, odg, ob, ecg, edg);
            chk("tbl_cpu_gnt", 32'(ocg), 32'(tbl[i].ecg));
            chk("tbl_dma_gnt", 32'(odg), 32'(tbl[i].edg));
            chk("tbl_boost",   32'(ob),  32'(tbl[i].eb));
            tick();
        end

        // Reset one cycle after a DMA read grant: the read must never return.
        do_cycle(0, mk(0, 16'h0000, 1, 8'h00, 1, 16'h9ABC, 1, 8'h00, 0, 1, 0), ocg, odg, ob, ecg, edg);
        chk("pre_rst_dma_gnt", 32'(odg), 32'd1);
        tick();
        do_cycle(1, mk(1, 16'h8001, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 0, 0, 0), ocg, odg, ob, ecg, edg);
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        tick();
        do_cycle(1, idle, ocg, odg, ob, ecg, edg);
        tick();
        do_cycle(0, mk(1, 16'h8001, 1, 8'h00, 0, 16'h0000, 1, 8'h00, 0, 0, 0), ocg, odg, ob, ecg, edg);
        chk("post_rst_cpu_gnt", 32'(ocg), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, idle, ocg, odg, ob, ecg, edg);
            chk("post_rst_no_dma_rvalid", 32'(dma_rvalid), 32'd0);
            tick();
        end

        // Random traffic; each master holds its request until the model grants it.
        pc = 0; pd = 0; pca = 0; pda = 0; pcrnw = 1; pdrnw = 1; pcwd = 0; pdwd = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pc && $urandom_range(0, 99) < 55) begin
                pc = 1; pca = 16'h8000 | 16'($urandom_range(0, 32767));
                pcrnw = ($urandom_range(0, 3) != 0); pcwd = 8'($urandom);
            end
            if (!pd && $urandom_range(0, 99) < 45) begin
                pd = 1; pda = 16'h8000 | 16'($urandom_range(0, 32767));
                pdrnw = ($urandom_range(0, 3) != 0); pdwd = 8'($urandom);
            end
            pend = mk(pc, pca, pcrnw, pcwd, pd, pda, pdrnw, pdwd, 0, 0, 0);
            do_cycle(($urandom_range(0, 199) == 0), pend, ocg, odg, ob, ecg, edg);
            if (ecg) pc = 0;
            if (edg) pd = 0;
            tick();
        end

        // Second build: run limit 1 gives strict alternation under contention.
        for (int k = 0; k < 6; k++) begin
            b_cpu_req = 1; b_cpu_addr = 16'h8100; b_cpu_rnw = 0; b_cpu_wdata = 8'(k);
            b_dma_req = 1; b_dma_addr = 16'h9100; b_dma_rnw = 0; b_dma_wdata = 8'(k);
            do_cycle(0, idle, ocg, odg, ob, ecg, edg);
            chk("alt_cpu_gnt", 32'(b_cpu_gnt), 32'(k % 2 == 0));
            chk("alt_dma_gnt", 32'(b_dma_gnt), 32'(k % 2 == 1));
            tick();
        end
        b_cpu_req = 0; b_dma_req = 0;
        for (int k = 0; k < 4; k++) begin
            do_cycle(0, idle, ocg, odg, ob, ecg, edg);
            tick();
        end

        // Second build, latency 3: back-to-back reads return from T+4 in order.
        for (int j = 0; j < 12; j++) begin
            b_cpu_req = (j < 6); b_cpu_addr = 16'(32'h8200 + j); b_cpu_rnw = 1;
            do_cycle(0, idle, ocg, odg, ob, ecg, edg);
            if (j < 6) chk("stream_cpu_gnt", 32'(b_cpu_gnt), 32'd1);
            chk("stream_cpu_rvalid", 32'(b_cpu_rvalid), 32'(j >= 4 && j <= 9));
            if (j >= 4 && j <= 9)
                chk("stream_cpu_rdata", 32'(b_cpu_rdata), 32'(f_rom(16'(32'h8200 + j - 4))));
            chk("stream_dma_rvalid", 32'(b_dma_rvalid), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
